mem_access_unit: RTL and testbench

- Memory-access stage sitting directly upstream of the write-back stage.
- Accepts one instruction at a time from the execute stage over a valid/ready handshake.
- Issues at most one load or store on a request/response data-memory bus, and aligns and extends load data.
- Presents memDataR plus registered pass-through fields to write-back, raising mfu_valid until write-back accepts.

---
 rtl/mem_access_unit_pkg.sv | 45 ++++
 rtl/mem_align.sv | 47 ++++
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_mem_access_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-access stage: memOp funct3, write-back select, FSM states.
// The captured-instruction struct keeps every field the stage holds for one instruction.
package mem_access_unit_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  localparam logic [1:0] WB_CSR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [1:0]  wbsel;
    logic [31:0] snpc;
    logic [31:0] csr;
  } inst_t;

  // Undefined encodings fall into the word case, including its alignment rule.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    logic mis;
    case (op)
      MEM_B, MEM_BU: mis = 1'b0;
      MEM_H, MEM_HU: mis = off[0];
      default:       mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational load extract/extend and store strobe/lane replication; zero latency.
// No handshake: outputs follow inputs directly.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] sdata,
  output logic [31:0] load_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rdata >> {off, 3'b000};
    load_data = shifted;
    wstrb     = 4'b1111;
    wdata     = sdata;
    case (op)
      MEM_B: begin
        load_data = {{24{shifted[7]}}, shifted[7:0]};
        wstrb     = 4'b0001 << off;
        wdata     = {4{sdata[7:0]}};
      end
      MEM_BU: begin
        load_data = {24'h0, shifted[7:0]};
        wstrb     = 4'b0001 << off;
        wdata     = {4{sdata[7:0]}};
      end
      MEM_H: begin
        load_data = {{16{shifted[15]}}, shifted[15:0]};
        wstrb     = 4'b0011 << off;
        wdata     = {2{sdata[15:0]}};
      end
      MEM_HU: begin
        load_data = {16'h0, shifted[15:0]};
        wstrb     = 4'b0011 << off;
        wdata     = {2{sdata[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: one instruction in flight; 1 cycle accept-to-valid without memory, 3 with a zero-wait bus.
// mfu_ready only in IDLE; request held until mem_req_ready; result held until wbu_ready.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_valid,
  output logic            mfu_ready,
  input  logic            memRen,
  input  logic            memWen,
  input  logic [2:0]      memOp,
  input  logic [XLEN-1:0] aluOut,
  input  logic [XLEN-1:0] storeData,
  input  logic [1:0]      WBSel_in,
  input  logic [XLEN-1:0] snpc_in,
  input  logic [XLEN-1:0] csrReadData_in,
  output logic            mfu_valid,
  input  logic            wbu_ready,
  output logic [1:0]      WBSel,
  output logic [XLEN-1:0] aluOut_q,
  output logic [XLEN-1:0] snpc,
  output logic [XLEN-1:0] csrReadData,
  output logic [XLEN-1:0] memDataR,
  output logic            err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [3:0]      mem_req_wstrb,
  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  input  logic [XLEN-1:0] mem_resp_rdata
);

  localparam int CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  inst_t             inst_q, inst_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0] load_data;
  logic [3:0]  strb;
  logic [31:0] lane_data;

  mem_align u_align (
    .op        (inst_q.op),
    .off       (inst_q.addr[1:0]),
    .rdata     (mem_resp_rdata),
    .sdata     (inst_q.sdata),
    .load_data (load_data),
    .wstrb     (strb),
    .wdata     (lane_data)
  );

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    mem_data_d = mem_data_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (exu_valid) begin
          // A store with the read flag also set is treated purely as a store.
          inst_d     = '{ren: memRen & ~memWen, wen: memWen, op: memOp, addr: aluOut,
                         sdata: storeData, wbsel: WBSel_in, snpc: snpc_in, csr: csrReadData_in};
          mem_data_d = '0;
          err_d      = 1'b0;
          cnt_d      = '0;
          if (!(memRen || memWen)) begin
            state_d = ST_DONE;
          end else if (misaligned(memOp, aluOut[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_resp_valid) begin
          mem_data_d = inst_q.ren ? load_data : 32'h0;
          state_d    = ST_DONE;
        end else if (RESP_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (wbu_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      inst_q     <= '0;
      mem_data_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      mem_data_q <= mem_data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mfu_ready      = (state_q == ST_IDLE);
  assign mfu_valid      = (state_q == ST_DONE);
  assign mem_req_valid  = (state_q == ST_REQ);
  assign mem_resp_ready = (state_q == ST_RESP);

  // Lane data and strobes are only meaningful for writes; reads present zeros.
  assign mem_req_wen   = inst_q.wen;
  assign mem_req_addr  = {inst_q.addr[31:2], 2'b00};
  assign mem_req_wstrb = inst_q.wen ? strb : 4'b0000;
  assign mem_req_wdata = inst_q.wen ? lane_data : 32'h0;

  assign WBSel       = inst_q.wbsel;
  assign aluOut_q    = inst_q.addr;
  assign snpc        = inst_q.snpc;
  assign csrReadData = inst_q.csr;
  assign memDataR    = mem_data_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table for single transactions
// plus hand sequences for bus stalls, response timeout and mid-transaction reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, mfu_ready, memRen, memWen;
  logic [2:0]  memOp;
  logic [31:0] aluOut, storeData, snpc_in, csrReadData_in;
  logic [1:0]  WBSel_in, WBSel;
  logic        mfu_valid, wbu_ready;
  logic [31:0] aluOut_q, snpc, csrReadData, memDataR;
  logic        err;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = -1;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .RESP_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .exu_valid(exu_valid), .mfu_ready(mfu_ready),
    .memRen(memRen), .memWen(memWen), .memOp(memOp), .aluOut(aluOut),
    .storeData(storeData), .WBSel_in(WBSel_in), .snpc_in(snpc_in),
    .csrReadData_in(csrReadData_in), .mfu_valid(mfu_valid), .wbu_ready(wbu_ready),
    .WBSel(WBSel), .aluOut_q(aluOut_q), .snpc(snpc), .csrReadData(csrReadData),
    .memDataR(memDataR), .err(err), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_wstrb(mem_req_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
  );

  typedef struct {
    logic        ren, wen;
    logic [2:0]  op;
    logic [31:0] addr, sdata, rdata;
    logic [1:0]  wbsel;
    logic        exp_err, exp_req;
    logic [31:0] exp_data, exp_addr, exp_wdata;
    logic [3:0]  exp_strb;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [vec %0d] t=%0t: got 0x%08h expected 0x%08h", name, cur, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ren, input logic wen, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input logic [1:0] wbsel,
                              input logic eerr, input logic ereq, input logic [31:0] edata,
                              input logic [3:0] estrb, input logic [31:0] ewdata);
    vec_t v;
    v.ren = ren; v.wen = wen; v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.wbsel = wbsel; v.exp_err = eerr; v.exp_req = ereq; v.exp_data = edata;
    v.exp_addr = {addr[31:2], 2'b00}; v.exp_strb = estrb; v.exp_wdata = ewdata;
    v.exp_lat = ereq ? 3 : 1;
    return v;
  endfunction

  task automatic offer(input logic ren, input logic wen, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [1:0] wbsel, input logic [31:0] rdata);
    exu_valid = 1'b1; memRen = ren; memWen = wen; memOp = op; aluOut = addr;
    storeData = sdata; WBSel_in = wbsel; snpc_in = addr + 32'd4;
    csrReadData_in = 32'hC0DE_0000 + 32'(cur); mem_resp_rdata = rdata;
  endtask

  task automatic scramble_inputs();
    exu_valid = 1'b0; memRen = 1'b1; memWen = 1'b1; memOp = 3'b111;
    aluOut = 32'hFFFF_FFFF; storeData = 32'h0; WBSel_in = 2'b11;
    snpc_in = 32'h0; csrReadData_in = 32'h0;
  endtask

  task automatic retire();
    wbu_ready = 1'b1;
    @(negedge clk);
    wbu_ready = 1'b0;
    chk("retire_valid_low", mfu_valid, 1'b0);
    chk("retire_ready_high", mfu_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat = 0;
    bit saw_req = 0;
    bit done = 0;
    @(negedge clk);
    chk("idle_ready", mfu_ready, 1'b1);
    offer(v.ren, v.wen, v.op, v.addr, v.sdata, v.wbsel, v.rdata);
    while (!done && lat < 20) begin
      @(negedge clk);
      if (lat == 0) scramble_inputs();
      lat++;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (mem_req_valid) begin
        if (!saw_req) begin
          chk("req_addr", mem_req_addr, v.exp_addr);
          chk("req_wen", mem_req_wen, v.wen);
          chk("req_wstrb", mem_req_wstrb, v.exp_strb);
          chk("req_wdata", mem_req_wdata, v.exp_wdata);
        end
        saw_req = 1;
        mem_req_ready = 1'b1;
      end
      if (mem_resp_ready) mem_resp_valid = 1'b1;
      if (mfu_valid) done = 1;
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    chk("done_in_budget", done, 1'b1);
    chk("latency", lat, v.exp_lat);
    chk("bus_traffic", saw_req, v.exp_req);
    chk("err", err, v.exp_err);
    chk("memDataR", memDataR, v.exp_data);
    chk("WBSel", WBSel, v.wbsel);
    chk("aluOut_q", aluOut_q, v.addr);
    chk("snpc", snpc, v.addr + 32'd4);
    chk("csrReadData", csrReadData, 32'hC0DE_0000 + 32'(cur));
    chk("done_ready_low", mfu_ready, 1'b0);
    retire();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; exu_valid = 1'b0; memRen = 1'b0; memWen = 1'b0; memOp = 3'b000;
    aluOut = '0; storeData = '0; WBSel_in = '0; snpc_in = '0; csrReadData_in = '0;
    wbu_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;

    //         ren wen op      addr          sdata         rdata         wb     err req exp_data      strb     wdata
    vecs.push_back(mk(0, 0, 3'b000, 32'h0000_1234, 32'h0,        32'h0,        2'b01, 0, 0, 32'h0,        4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h8000_0003, 32'h0,        32'h80FF_0000, 2'b00, 0, 1, 32'hFFFF_FF80, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b100, 32'h8000_0003, 32'h0,        32'h80FF_0000, 2'b00, 0, 1, 32'h0000_0080, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 32'hDEAD_BEEF, 2'b00, 0, 1, 32'h0,        4'hC, 32'h1234_1234));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0,        4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_1234, 2'b00, 0, 1, 32'hFFFF_8001, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_1234, 2'b00, 0, 1, 32'h0000_8001, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0004, 32'h0,        32'hCAFE_BABE, 2'b00, 0, 1, 32'hCAFE_BABE, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0,        2'b00, 0, 1, 32'h0,        4'h2, 32'hA5A5_A5A5));
    vecs.push_back(mk(0, 1, 3'b000, 32'h0000_0003, 32'h1234_5678, 32'h0,        2'b00, 0, 1, 32'h0,        4'h8, 32'h7878_7878));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0300, 32'h1122_3344, 32'h0000_0099, 2'b00, 0, 1, 32'h0,        4'hF, 32'h1122_3344));
    vecs.push_back(mk(1, 1, 3'b010, 32'h0000_0008, 32'h0000_0055, 32'h7777_7777, 2'b00, 0, 1, 32'h0,        4'hF, 32'h0000_0055));
    vecs.push_back(mk(1, 0, 3'b011, 32'h0000_000C, 32'h0,        32'h89AB_CDEF, 2'b00, 0, 1, 32'h89AB_CDEF, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b011, 32'h0000_000D, 32'h0,        32'h89AB_CDEF, 2'b00, 1, 0, 32'h0,        4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0001, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0,        4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0103, 32'hFFFF_FFFF, 32'h0,        2'b00, 1, 0, 32'h0,        4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0001, 32'h0,        32'h0000_7F00, 2'b00, 0, 1, 32'h0000_007F, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 3'b010, 32'hFFFF_FFFF, 32'h0,        32'h0,        2'b10, 0, 0, 32'h0,        4'h0, 32'h0));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_mfu_valid", mfu_valid, 1'b0);
    chk("rst_mfu_ready", mfu_ready, 1'b1);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_resp_ready", mem_resp_ready, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_memDataR", memDataR, 32'h0);
    chk("rst_aluOut_q", aluOut_q, 32'h0);
    chk("rst_snpc", snpc, 32'h0);
    chk("rst_csr", csrReadData, 32'h0);
    chk("rst_WBSel", WBSel, 2'b00);
    chk("rst_wstrb", mem_req_wstrb, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      cur = i;
      run_vec(vecs[i]);
    end

    // Bus stalls: request held 5 cycles, response 3 more, write-back 2 more.
    cur = 100;
    @(negedge clk);
    offer(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 2'b00, 32'h1234_5678);
    @(negedge clk);
    scramble_inputs();
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", mem_req_valid, 1'b1);
      chk("stall_req_addr", mem_req_addr, 32'h0000_0040);
      chk("stall_req_wen", mem_req_wen, 1'b0);
      chk("stall_mfu_ready", mfu_ready, 1'b0);
      chk("stall_mfu_valid", mfu_valid, 1'b0);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_resp_ready", mem_resp_ready, 1'b1);
      chk("stall_resp_req_low", mem_req_valid, 1'b0);
      chk("stall_resp_mfu_valid", mfu_valid, 1'b0);
      @(negedge clk);
    end
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    chk("stall_done_valid", mfu_valid, 1'b1);
    chk("stall_data", memDataR, 32'h1234_5678);
    chk("stall_err", err, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wb_hold_valid", mfu_valid, 1'b1);
      chk("wb_hold_ready", mfu_ready, 1'b0);
      chk("wb_hold_data", memDataR, 32'h1234_5678);
      chk("wb_hold_alu", aluOut_q, 32'h0000_0040);
    end
    retire();

    // Response never arrives: abandoned after 255 RESP cycles.
    cur = 101;
    @(negedge clk);
    offer(1'b1, 1'b0, 3'b010, 32'h0000_0050, 32'h0, 2'b00, 32'hFFFF_FFFF);
    @(negedge clk);
    scramble_inputs();
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    cnt = 0;
    while (!mfu_valid && cnt < 400) begin
      if (mem_resp_ready) cnt++;
      @(negedge clk);
    end
    chk("timeout_valid", mfu_valid, 1'b1);
    chk("timeout_cycles", cnt, 255);
    chk("timeout_err", err, 1'b1);
    chk("timeout_data", memDataR, 32'h0);
    retire();

    // Reset while waiting for a response; the late response must be ignored.
    cur = 102;
    @(negedge clk);
    offer(1'b1, 1'b0, 3'b010, 32'h0000_0060, 32'h0, 2'b00, 32'hFFFF_FFFF);
    @(negedge clk);
    scramble_inputs();
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rst_mid_in_resp", mem_resp_ready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    chk("rst_mid_ready", mfu_ready, 1'b1);
    chk("rst_mid_valid", mfu_valid, 1'b0);
    chk("rst_mid_req", mem_req_valid, 1'b0);
    chk("rst_mid_resp_ready", mem_resp_ready, 1'b0);
    chk("rst_mid_data", memDataR, 32'h0);
    chk("rst_mid_alu", aluOut_q, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stale_resp_valid", mfu_valid, 1'b0);
      chk("stale_resp_ready", mfu_ready, 1'b1);
      chk("stale_resp_data", memDataR, 32'h0);
    end
    mem_resp_valid = 1'b0;
    cur = 2;
    run_vec(vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
